// File: rtl/func_field_stage.sv
// Gates FUNC3/FUNC7 by the one-hot instruction-type code and holds the result in a 2-entry skid buffer.
// Optional macro FUNC_ONEHOT_CHECK_EN: flag and zero entries whose type code is not exactly one-hot.
module func_field_stage #(
  parameter int                 CODE_W  = 10,
  parameter int                 FUNC3_W = 3,
  parameter int                 FUNC7_W = 7,
  parameter logic [CODE_W-1:0]  F3_MASK = 10'b1010100100,
  parameter logic [CODE_W-1:0]  F7_MASK = 10'b0010100000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [CODE_W-1:0]  CODE,
  input  logic [FUNC3_W-1:0] INSN_F3,
  input  logic [FUNC7_W-1:0] INSN_F7,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [FUNC3_W-1:0] FUNC3,
  output logic [FUNC7_W-1:0] FUNC7,
  output logic               CODE_ERR
);

  // state | meaning
  // EMPTY | no entry buffered, outputs held at 0
  // ONE   | main register valid and driving the outputs
  // TWO   | main and skid registers valid, upstream stalled
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t             state_q;
  logic [FUNC3_W-1:0] main_f3_q, skid_f3_q;
  logic [FUNC7_W-1:0] main_f7_q, skid_f7_q;
  logic [FUNC3_W-1:0] in_f3_d;
  logic [FUNC7_W-1:0] in_f7_d;
  logic               in_xfer, out_xfer;

  assign IN_READY  = !RESET && (state_q != TWO);
  assign OUT_VALID = (state_q != EMPTY);
  assign in_xfer   = IN_VALID && IN_READY;
  assign out_xfer  = OUT_VALID && OUT_READY;
  assign FUNC3     = main_f3_q;
  assign FUNC7     = main_f7_q;

`ifdef FUNC_ONEHOT_CHECK_EN
  logic in_err_d;
  logic main_err_q, skid_err_q;

  assign in_err_d = !$onehot(CODE);
  assign in_f3_d  = (!in_err_d && ((CODE & F3_MASK) != '0)) ? INSN_F3 : '0;
  assign in_f7_d  = (!in_err_d && ((CODE & F7_MASK) != '0)) ? INSN_F7 : '0;
  assign CODE_ERR = main_err_q;

  // err travels alongside its entry; cleared whenever the slot empties
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      main_err_q <= 1'b0;
      skid_err_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) main_err_q <= in_err_d;
        ONE: begin
          if (in_xfer && out_xfer) main_err_q <= in_err_d;
          else if (in_xfer)        skid_err_q <= in_err_d;
          else if (out_xfer)       main_err_q <= 1'b0;
        end
        TWO: if (out_xfer) begin
          main_err_q <= skid_err_q;
          skid_err_q <= 1'b0;
        end
        default: begin
          main_err_q <= 1'b0;
          skid_err_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign in_f3_d  = ((CODE & F3_MASK) != '0) ? INSN_F3 : '0;
  assign in_f7_d  = ((CODE & F7_MASK) != '0) ? INSN_F7 : '0;
  assign CODE_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      state_q   <= EMPTY;
      main_f3_q <= '0;
      main_f7_q <= '0;
      skid_f3_q <= '0;
      skid_f7_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_f3_q <= in_f3_d;
            main_f7_q <= in_f7_d;
            state_q   <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_f3_q <= in_f3_d;
            main_f7_q <= in_f7_d;
          end else if (in_xfer) begin
            skid_f3_q <= in_f3_d;
            skid_f7_q <= in_f7_d;
            state_q   <= TWO;
          end else if (out_xfer) begin
            main_f3_q <= '0;
            main_f7_q <= '0;
            state_q   <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_f3_q <= skid_f3_q;
            main_f7_q <= skid_f7_q;
            skid_f3_q <= '0;
            skid_f7_q <= '0;
            state_q   <= ONE;
          end
        end
        default: begin
          state_q   <= EMPTY;
          main_f3_q <= '0;
          main_f7_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_field_stage.sv
// Randomized and directed bench for func_field_stage against a queue-based FIFO model.
module tb_func_field_stage;

  localparam logic [9:0] F3M = 10'b1010100100;
  localparam logic [9:0] F7M = 10'b0010100000;

  logic       CLK = 1'b0;
  logic       RESET, FLUSH, IN_VALID, OUT_READY;
  logic [9:0] CODE;
  logic [2:0] INSN_F3;
  logic [6:0] INSN_F7;
  logic       IN_READY, OUT_VALID, CODE_ERR;
  logic [2:0] FUNC3;
  logic [6:0] FUNC7;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] f3;
    logic [6:0] f7;
    logic       err;
  } ent_t;
  ent_t model_q[$];

  always #5 CLK = ~CLK;

  func_field_stage dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .CODE(CODE), .INSN_F3(INSN_F3), .INSN_F7(INSN_F7),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .FUNC3(FUNC3), .FUNC7(FUNC7), .CODE_ERR(CODE_ERR)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic ent_t make_ent(input logic [9:0] code, input logic [2:0] f3, input logic [6:0] f7);
    ent_t e;
    int   hot;
    hot   = $countones(code);
`ifdef FUNC_ONEHOT_CHECK_EN
    e.err = (hot != 1);
`else
    e.err = 1'b0;
`endif
    e.f3  = (!e.err && (code & F3M) != 0) ? f3 : 3'd0;
    e.f7  = (!e.err && (code & F7M) != 0) ? f7 : 7'd0;
    return e;
  endfunction

  // drive one cycle, check outputs against the model, then advance the model
  task automatic cycle(input logic rst, input logic fl, input logic iv, input logic [9:0] code,
                       input logic [2:0] f3, input logic [6:0] f7, input logic ordy);
    int   sz;
    ent_t e;
    @(negedge CLK);
    RESET = rst; FLUSH = fl; IN_VALID = iv; CODE = code;
    INSN_F3 = f3; INSN_F7 = f7; OUT_READY = ordy;
    #1;
    sz = model_q.size();
    check("in_ready", IN_READY, (!rst && sz < 2));
    check("out_valid", OUT_VALID, (sz > 0));
    if (sz > 0) begin
      check("func3", FUNC3, model_q[0].f3);
      check("func7", FUNC7, model_q[0].f7);
      check("code_err", CODE_ERR, model_q[0].err);
    end else begin
      check("func3_empty", FUNC3, 0);
      check("func7_empty", FUNC7, 0);
      check("code_err_empty", CODE_ERR, 0);
    end
    @(posedge CLK);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      e = make_ent(code, f3, f7);
      if (ordy && sz > 0) void'(model_q.pop_front());
      if (iv && sz < 2) model_q.push_back(e);
    end
  endtask

  localparam logic [9:0] R_CODE = 10'b0000100000;

  initial begin
    logic [9:0] c;
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    CODE = '0; INSN_F3 = '0; INSN_F7 = '0;
    repeat (2) @(posedge CLK);
    model_q.delete();
    cycle(1, 0, 0, '0, 0, 0, 0);

    // test 1: R-type passes both fields with latency 1
    cycle(0, 0, 1, R_CODE, 3'b101, 7'b0100000, 1);
    #1;
    check("t1_valid", OUT_VALID, 1);
    check("t1_f3", FUNC3, 3'b101);
    check("t1_f7", FUNC7, 7'b0100000);
    cycle(0, 0, 0, '0, 0, 0, 1);

    // test 2: sweep one-hot codes
    for (int b = 0; b < 10; b++) begin
      c = '0;
      c[b] = 1'b1;
      cycle(0, 0, 1, c, 3'b111, 7'h7F, 1);
      #1;
      check($sformatf("t2_f3_b%0d", b), FUNC3, (b == 2 || b == 5 || b == 7 || b == 9) ? 3'b111 : 3'b000);
      check($sformatf("t2_f7_b%0d", b), FUNC7, (b == 5 || b == 7) ? 7'h7F : 7'h00);
    end
    cycle(0, 0, 0, '0, 0, 0, 1);

    // test 3: stall, skid fill, FIFO drain
    cycle(0, 0, 1, R_CODE, 3'd1, 7'h11, 0);
    cycle(0, 0, 1, R_CODE, 3'd2, 7'h22, 0);
    #1;
    check("t3_ready_full", IN_READY, 0);
    check("t3_head_a", FUNC3, 3'd1);
    cycle(0, 0, 1, R_CODE, 3'd3, 7'h33, 1);
    #1;
    check("t3_head_b", FUNC3, 3'd2);
    check("t3_head_b7", FUNC7, 7'h22);
    cycle(0, 0, 1, R_CODE, 3'd3, 7'h33, 1);
    #1;
    check("t3_head_c", FUNC3, 3'd3);
    cycle(0, 0, 0, '0, 0, 0, 1);
    #1;
    check("t3_drained", OUT_VALID, 0);

    // test 4: flush in TWO drops buffered and presented entries
    cycle(0, 0, 1, R_CODE, 3'd4, 7'h44, 0);
    cycle(0, 0, 1, R_CODE, 3'd5, 7'h55, 0);
    cycle(0, 1, 1, R_CODE, 3'd6, 7'h66, 1);
    #1;
    check("t4_valid", OUT_VALID, 0);
    check("t4_ready", IN_READY, 1);
    check("t4_f3", FUNC3, 0);
    cycle(0, 0, 0, '0, 0, 0, 1);

    // test 5: reset in TWO
    cycle(0, 0, 1, R_CODE, 3'd1, 7'h01, 0);
    cycle(0, 0, 1, R_CODE, 3'd2, 7'h02, 0);
    cycle(1, 0, 0, '0, 0, 0, 1);
    #1;
    check("t5_valid", OUT_VALID, 0);
    check("t5_f3", FUNC3, 0);
    check("t5_f7", FUNC7, 0);
    check("t5_ready_in_rst", IN_READY, 0);
    cycle(0, 0, 0, '0, 0, 0, 1);

    // test 6: multi-hot code
    cycle(0, 0, 1, 10'b0000100100, 3'b011, 7'h00, 1);
    #1;
`ifdef FUNC_ONEHOT_CHECK_EN
    check("t6_err", CODE_ERR, 1);
    check("t6_f3", FUNC3, 3'b000);
`else
    check("t6_err", CODE_ERR, 0);
    check("t6_f3", FUNC3, 3'b011);
`endif
    cycle(0, 0, 0, '0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [9:0] rc;
      if ($urandom_range(0, 3) == 0) rc = 10'($urandom);
      else begin
        rc = '0;
        rc[$urandom_range(0, 9)] = 1'b1;
      end
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0), 1'($urandom),
            rc, 3'($urandom), 7'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/func_field_stage.md
Name: func_field_stage

Overview:
Registered, parametrised successor of the FUNC3 gate in the control unit.
- Gates the FUNC3 and FUNC7 fields of the decoded instruction by the one-hot instruction-type CODE; one mask per field selects which types pass the field.
- Result is held in a 2-entry skid buffer with a valid/ready handshake and a flush input.
- Sits between the opcode decoder and the ALU-control stage of the pipelined CPU.

Parameters:
- CODE_W, 10, width of the one-hot type code. Bit order: J, I-JALR, U-LUI, U-AUIPC, B, R, S, I-ALU, I-LOAD, I-CSR (bit0..bit9).
- FUNC3_W, 3, width of the FUNC3 field.
- FUNC7_W, 7, width of the FUNC7 field.
- F3_MASK, 10'b1010100100, CODE bits that pass FUNC3 (LUI, R, I-ALU, CSR).
- F7_MASK, 10'b0010100000, CODE bits that pass FUNC7 (R, I-ALU).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- FLUSH  input  1  synchronous discard of all buffered entries.
- IN_VALID  input  1  upstream entry present.
- IN_READY  output  1  stage can accept an entry.
- CODE  input  CODE_W  one-hot instruction type.
- INSN_F3  input  FUNC3_W  raw FUNC3 field of the instruction.
- INSN_F7  input  FUNC7_W  raw FUNC7 field of the instruction.
- OUT_VALID  output  1  output entry valid.
- OUT_READY  input  1  downstream accepts the output entry.
- FUNC3  output  FUNC3_W  gated FUNC3.
- FUNC7  output  FUNC7_W  gated FUNC7.
- CODE_ERR  output  1  CODE of the output entry was not one-hot (see Optional Feature).

Behaviour:
- Gating, combinational before capture:
  - f3 = INSN_F3 when (CODE & F3_MASK) != 0, else 0.
  - f7 = INSN_F7 when (CODE & F7_MASK) != 0, else 0.
  - CODE = 0 gives 0 for both fields.
  - A multi-hot CODE passes a field if any set bit is in that field's mask.
- Transfers:
  - Input transfer when IN_VALID & IN_READY at the rising edge.
  - Output transfer when OUT_VALID & OUT_READY at the rising edge.
- Storage: main register (drives the outputs) and skid register.
- State machine states: EMPTY (0 entries), ONE (main valid), TWO (main + skid valid).
- Transitions:
  - EMPTY + input -> ONE. Data appears on the outputs the next cycle (latency 1).
  - ONE + input, no output -> TWO. The new entry goes to the skid register.
  - ONE + output, no input -> EMPTY.
  - ONE + input + output -> ONE. The main register loads the new entry.
  - TWO + output -> ONE. The skid entry moves to main. No input is possible in TWO.
  - All other combinations hold state and data.
- IN_READY = 1 in EMPTY and ONE, 0 in TWO. It is derived from registered state only, with no combinational path from OUT_READY.
- OUT_VALID = 1 in ONE and TWO.
- Output data is stable while OUT_VALID & !OUT_READY. Order is strictly FIFO.
- FLUSH: next state EMPTY; any input presented in the same cycle is dropped. FLUSH has priority over input and output transfers.
- RESET: has priority over FLUSH. During and after the reset cycle:
  - State EMPTY, OUT_VALID=0, FUNC3=0, FUNC7=0, CODE_ERR=0.
  - IN_READY=0 while RESET is high, 1 from the first cycle after.
- Reset mid-operation discards all entries; no output transfer completes on that edge.
- Output data registers are cleared to 0 whenever state becomes EMPTY.

Optional Feature:
- Macro: FUNC_ONEHOT_CHECK_EN.
- Defined:
  - Each captured entry records err = (CODE is not exactly one-hot), i.e. CODE == 0 or more than one bit set.
  - An entry with err=1 stores FUNC3=0 and FUNC7=0, overriding the mask rule.
  - CODE_ERR shows the err of the current output entry and moves with the entry through the skid register.
- Undefined: CODE_ERR tied to 0; multi-hot/zero CODE follows the mask rule only; no err storage is inferred.

Test Plan:
1. Reset, then CODE=10'b0000100000 (R), INSN_F3=3'b101, INSN_F7=7'b0100000, IN_VALID=1, OUT_READY=1 -> next cycle OUT_VALID=1, FUNC3=101, FUNC7=0100000.
2. Sweep all 10 one-hot CODE values with INSN_F3=3'b111, INSN_F7=7'h7F, OUT_READY=1:
   - FUNC3=111 only for bits 2, 5, 7, 9, else 000.
   - FUNC7=7'h7F only for bits 5, 7, else 0.
3. OUT_READY=0, three back-to-back inputs A, B, C:
   - A and B accepted; IN_READY=0 after B; C held upstream.
   - Raise OUT_READY: outputs A, B, C in order, none lost or duplicated.
4. State TWO, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, FUNC3=0; flushed entries never appear.
5. RESET asserted in state TWO with OUT_READY=1 -> next cycle OUT_VALID=0, all outputs 0; IN_READY=0 during reset, 1 after.
6. With FUNC_ONEHOT_CHECK_EN defined, CODE=10'b0000100100, INSN_F3=3'b011 -> CODE_ERR=1, FUNC3=000. Without the macro -> CODE_ERR=0, FUNC3=011.
